mme_top_unit: RTL and testbench
===============================

MME_TOP_UNIT -- requirements
Module: mme_top_unit

Interface
REQ-001 SHALL have parameter IP_VER, default 32'h0001_2021, the value returned by the IP_VER register.
REQ-002 SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit, the reset; asynchronous, active-high.
REQ-004 SHALL have port apb_if, APB slave interface, 32-bit address and data, the register access path.
REQ-005 SHALL have port axi_ar_if, AXI read-address master interface, 32-bit address, issuing matrix A/B read requests.
REQ-006 SHALL have port axi_r_if, AXI read-data interface, 32-bit data, input side of reads.
REQ-007 SHALL have port axi_aw_if, AXI write-address master interface, 32-bit address, issuing matrix C write requests.
REQ-008 SHALL have port axi_w_if, AXI write-data interface, 32-bit data.
REQ-009 SHALL have port axi_b_if, AXI write-response interface.

Function
REQ-010 SHALL decode these APB registers:
- 0x000 IP_VER, RO
- 0x100 MAT_CFG, RW; width N = bits [7:0]
- 0x200 A_ADDR, RW
- 0x204 B_ADDR, RW
- 0x208 C_ADDR, RW
- 0x20C CMD, WO; bit0=1 starts
- 0x210 STATUS, RO; bit0 = done
REQ-011 APB SHALL complete with zero wait states: pready=1, pslverr=0; unmapped reads return 0; every RW register reads back the full 32-bit value written.
REQ-012 SHALL compute C(4x4) = A(4xN) x B(Nx4) on signed 32-bit words, with products and sums truncated modulo 2^32.
REQ-013 Memory layout SHALL be:
- A column-major: word A[r][k] at A_ADDR + (4k+r)*4
- B row-major: word B[k][c] at B_ADDR + (4k+c)*4
- C row-major: word C[r][c] at C_ADDR + (4r+c)*4
REQ-014 The FSM SHALL have states IDLE, RD_A, RD_B, MAC, WR_AW, WR_W, WR_B, DONE.
REQ-015 A CMD write with bit0=1 SHALL, in IDLE or DONE, clear the 16 accumulators, clear STATUS and go to RD_A; it SHALL be ignored in all other states.
REQ-016 For each k in 0..N-1, SHALL perform:
- one 4-beat INCR read of A column k (arlen=3, arsize=3'b010, arid=0)
- one 4-beat read of B row k
- 16 accumulations, C[r][c] += A[r][k]*B[k][c], with one B beat processed per cycle using 4 multipliers
REQ-017 SHALL have at most one outstanding AXI transaction; arvalid/awvalid/wvalid SHALL be held until accepted; rready=1 only in read states; bready=1 only in WR_B.
REQ-018 Writeback SHALL be four 4-beat INCR bursts, one per C row, with wlast on beat 3, each waiting for its B response before the next row begins.
REQ-019 After the 4th B response the FSM SHALL enter DONE and STATUS SHALL read 1 until the next start.
REQ-020 N=0 SHALL skip all reads and write an all-zero C.

Reset
REQ-021 While rst_n=1, all of the following SHALL hold immediately, including when reset occurs mid-transfer:
- FSM in IDLE
- all registers and accumulators at 0
- arvalid, awvalid, wvalid, rready, bready, wlast at 0
- STATUS at 0

Configuration
REQ-022 With macro MME_RESP_CHECK_EN defined, any nonzero rresp or bresp SHALL set STATUS bit1 (error) and bit0, and move the FSM to DONE after the current burst completes; without the macro, responses SHALL be ignored and STATUS bit1 SHALL read 0.

Verification
REQ-023 Reset release, then a read at 0x000 -> returns 32'h0001_2021.
REQ-024 Write and read back 0x100=4, 0x200=0, 0x204=0x1000, 0x208=0x2000 -> each reads back exactly the value written.
REQ-025 N=4, A=identity, B[k][c]=4k+c, CMD=1 -> STATUS becomes 1; memory at 0x2000..0x203C holds 0..15.
REQ-026 N=8, 12 and 16 with random bytes 0..255 -> every C word equals the software dot product [31:0].
REQ-027 CMD write while busy -> ignored, and the result is unchanged.
REQ-028 Assert rst_n during RD_B -> all valid outputs drop the same cycle and STATUS=0; a rerun after release passes.

Source files
------------

// File: rtl/mme_top_unit_if.sv
// Bus interfaces for mme_top_unit: APB register slave plus the five AXI
// channels used to read matrices A/B and write matrix C.
interface mme_apb_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    modport slave (input paddr, psel, penable, pwrite, pwdata,
                   output prdata, pready, pslverr);
endinterface

interface mme_axi_ar_if;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid;
    logic        arvalid;
    logic        arready;
    modport master (output araddr, arlen, arsize, arburst, arid, arvalid,
                    input arready);
endinterface

interface mme_axi_r_if;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    modport master (input rdata, rresp, rlast, rvalid, output rready);
endinterface

interface mme_axi_aw_if;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awid;
    logic        awvalid;
    logic        awready;
    modport master (output awaddr, awlen, awsize, awburst, awid, awvalid,
                    input awready);
endinterface

interface mme_axi_w_if;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    modport master (output wdata, wstrb, wlast, wvalid, input wready);
endinterface

interface mme_axi_b_if;
    logic [1:0] bresp;
    logic       bvalid;
    logic       bready;
    modport master (input bresp, bvalid, output bready);
endinterface

// File: rtl/mme_top_unit.sv
// 4xN by Nx4 matrix multiply engine with APB registers and AXI burst master.
// Optional response checking is enabled with macro MME_RESP_CHECK_EN.
module mme_top_unit #(
    parameter logic [31:0] IP_VER = 32'h0001_2021
) (
    input logic           clk,
    input logic           rst_n,
    mme_apb_if.slave      apb_if,
    mme_axi_ar_if.master  axi_ar_if,
    mme_axi_r_if.master   axi_r_if,
    mme_axi_aw_if.master  axi_aw_if,
    mme_axi_w_if.master   axi_w_if,
    mme_axi_b_if.master   axi_b_if
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR_AW, WR_W, WR_B, DONE} state_t;

    state_t      state, next_state;
    logic [31:0] mat_cfg, a_addr, b_addr, c_addr;
    logic [31:0] a_col [4];
    logic [31:0] b_row [4];
    logic [31:0] acc [4][4];
    logic [7:0]  k_idx, n_width;
    logic [1:0]  beat, row;
    logic        ar_sent, err_q, resp_err;
    logic        apb_wr, start, r_hs, w_hs, b_hs, last_k;

    assign n_width = mat_cfg[7:0];
    assign apb_wr  = apb_if.psel & apb_if.penable & apb_if.pwrite;
    assign start   = apb_wr && (apb_if.paddr == 32'h20C) && apb_if.pwdata[0]
                     && ((state == IDLE) || (state == DONE));
    assign r_hs    = axi_r_if.rvalid & axi_r_if.rready;
    assign w_hs    = axi_w_if.wvalid & axi_w_if.wready;
    assign b_hs    = axi_b_if.bvalid & axi_b_if.bready;
    assign last_k  = ((k_idx + 8'd1) == n_width);

`ifdef MME_RESP_CHECK_EN
    // An error is remembered for STATUS and cuts the run short at the next burst end.
    assign resp_err = err_q | (r_hs && (axi_r_if.rresp != 2'b00))
                            | (b_hs && (axi_b_if.bresp != 2'b00));
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            err_q <= 1'b0;
        else if (start)
            err_q <= 1'b0;
        else if (resp_err)
            err_q <= 1'b1;
    end
    logic unused_sig;
    assign unused_sig = axi_r_if.rlast;
`else
    assign resp_err = 1'b0;
    assign err_q    = 1'b0;
    logic unused_sig;
    assign unused_sig = ^{axi_r_if.rlast, axi_r_if.rresp, axi_b_if.bresp};
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = RD_A;
            RD_A: begin
                if (n_width == 8'd0)
                    next_state = WR_AW;
                else if (r_hs && (beat == 2'd3))
                    next_state = resp_err ? DONE : RD_B;
            end
            RD_B:  if (r_hs && (beat == 2'd3)) next_state = resp_err ? DONE : MAC;
            MAC:   if (beat == 2'd3) next_state = last_k ? WR_AW : RD_A;
            WR_AW: if (axi_aw_if.awready) next_state = WR_W;
            WR_W:  if (w_hs && (beat == 2'd3)) next_state = WR_B;
            WR_B:  if (b_hs) next_state = (resp_err || (row == 2'd3)) ? DONE : WR_AW;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        axi_ar_if.arvalid = (((state == RD_A) && (n_width != 8'd0)) || (state == RD_B)) && !ar_sent;
        axi_ar_if.araddr  = ((state == RD_B) ? b_addr : a_addr) + {20'd0, k_idx, 4'd0};
        axi_ar_if.arlen   = 8'd3;
        axi_ar_if.arsize  = 3'b010;
        axi_ar_if.arburst = 2'b01;
        axi_ar_if.arid    = 4'd0;
        axi_r_if.rready   = (state == RD_A) || (state == RD_B);
        axi_aw_if.awvalid = (state == WR_AW);
        axi_aw_if.awaddr  = c_addr + {26'd0, row, 4'd0};
        axi_aw_if.awlen   = 8'd3;
        axi_aw_if.awsize  = 3'b010;
        axi_aw_if.awburst = 2'b01;
        axi_aw_if.awid    = 4'd0;
        axi_w_if.wvalid   = (state == WR_W);
        axi_w_if.wdata    = acc[row][beat];
        axi_w_if.wstrb    = 4'hF;
        axi_w_if.wlast    = (state == WR_W) && (beat == 2'd3);
        axi_b_if.bready   = (state == WR_B);
    end

    always_comb begin
        case (apb_if.paddr)
            32'h000: apb_if.prdata = IP_VER;
            32'h100: apb_if.prdata = mat_cfg;
            32'h200: apb_if.prdata = a_addr;
            32'h204: apb_if.prdata = b_addr;
            32'h208: apb_if.prdata = c_addr;
            32'h210: apb_if.prdata = {30'd0, err_q, state == DONE};
            default: apb_if.prdata = 32'd0;
        endcase
    end
    assign apb_if.pready  = 1'b1;
    assign apb_if.pslverr = 1'b0;

    // The shared beat counter wraps to 0 at the end of every 4-beat phase.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mat_cfg <= '0;
            a_addr  <= '0;
            b_addr  <= '0;
            c_addr  <= '0;
            k_idx   <= '0;
            beat    <= '0;
            row     <= '0;
            ar_sent <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_col[i] <= '0;
                b_row[i] <= '0;
                for (int j = 0; j < 4; j++) acc[i][j] <= '0;
            end
        end else begin
            if (apb_wr) begin
                case (apb_if.paddr)
                    32'h100: mat_cfg <= apb_if.pwdata;
                    32'h200: a_addr  <= apb_if.pwdata;
                    32'h204: b_addr  <= apb_if.pwdata;
                    32'h208: c_addr  <= apb_if.pwdata;
                    default: ;
                endcase
            end
            if (start) begin
                k_idx   <= '0;
                beat    <= '0;
                row     <= '0;
                ar_sent <= 1'b0;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) acc[i][j] <= '0;
            end else begin
                case (state)
                    RD_A, RD_B: begin
                        if (axi_ar_if.arvalid && axi_ar_if.arready) ar_sent <= 1'b1;
                        if (r_hs) begin
                            if (state == RD_A) a_col[beat] <= axi_r_if.rdata;
                            else               b_row[beat] <= axi_r_if.rdata;
                            beat <= beat + 2'd1;
                            if (beat == 2'd3) ar_sent <= 1'b0;
                        end
                    end
                    MAC: begin
                        for (int r = 0; r < 4; r++)
                            acc[r][beat] <= acc[r][beat] + a_col[r] * b_row[beat];
                        beat <= beat + 2'd1;
                        if (beat == 2'd3) k_idx <= k_idx + 8'd1;
                    end
                    WR_W: if (w_hs) beat <= beat + 2'd1;
                    WR_B: if (b_hs) row <= row + 2'd1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mme_top_unit.sv
// Self-checking bench for mme_top_unit: APB register table plus AXI memory model.
module tb_mme_top_unit;
    localparam logic [31:0] A_BASE = 32'h0000_0000;
    localparam logic [31:0] B_BASE = 32'h0000_1000;
    localparam logic [31:0] C_BASE = 32'h0000_2000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mme_apb_if    apb ();
    mme_axi_ar_if ar ();
    mme_axi_r_if  r ();
    mme_axi_aw_if aw ();
    mme_axi_w_if  w ();
    mme_axi_b_if  b ();

    mme_top_unit dut (
        .clk(clk), .rst_n(rst_n), .apb_if(apb), .axi_ar_if(ar), .axi_r_if(r),
        .axi_aw_if(aw), .axi_w_if(w), .axi_b_if(b)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] mem [0:4095];
    int          rd_left, wr_beat, ar_count, aw_count;
    logic [31:0] rd_addr, wr_addr;
    logic        wr_active, b_pending;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
        string       name;
    } apb_vec_t;
    apb_vec_t vecs [16];

    function automatic int widx(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
        apb.paddr = addr; apb.pwdata = data;
        @(negedge clk);
        apb.penable = 1'b1;
        @(negedge clk);
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = addr;
        @(negedge clk);
        apb.penable = 1'b1;
        #1;
        data = apb.prdata;
        check_output("pready", {31'd0, apb.pready}, 32'd1);
        check_output("pslverr", {31'd0, apb.pslverr}, 32'd0);
        @(negedge clk);
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    task automatic apply_stimulus(input apb_vec_t v);
        logic [31:0] rd;
        if (v.is_write) begin
            apb_write(v.addr, v.data);
        end else begin
            apb_read(v.addr, rd);
            check_output(v.name, rd, v.data);
        end
    endtask

    // AXI slave memory: decisions made at negedge describe the transfer at the next posedge.
    initial begin
        rd_left = 0; wr_beat = 0; ar_count = 0; aw_count = 0;
        rd_addr = '0; wr_addr = '0; wr_active = 1'b0; b_pending = 1'b0;
        ar.arready = 1'b0; r.rvalid = 1'b0; r.rdata = '0; r.rresp = 2'b00; r.rlast = 1'b0;
        aw.awready = 1'b0; w.wready = 1'b0; b.bvalid = 1'b0; b.bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                rd_left = 0; wr_active = 1'b0; b_pending = 1'b0;
                ar.arready = 1'b0; r.rvalid = 1'b0; r.rlast = 1'b0;
                aw.awready = 1'b0; w.wready = 1'b0; b.bvalid = 1'b0;
            end else begin
                r.rvalid = (rd_left > 0);
                r.rdata  = r.rvalid ? mem[widx(rd_addr)] : 32'h0;
                r.rlast  = (rd_left == 1);
                if (r.rvalid && r.rready) begin
                    rd_addr = rd_addr + 32'd4;
                    rd_left--;
                end
                ar.arready = (rd_left == 0) && ($urandom_range(0, 3) != 0);
                if (ar.arvalid && ar.arready) begin
                    check_output("arlen", {24'd0, ar.arlen}, 32'd3);
                    check_output("arsize", {29'd0, ar.arsize}, 32'd2);
                    rd_addr = ar.araddr;
                    rd_left = 4;
                    ar_count++;
                end
                b.bvalid = b_pending;
                if (b.bvalid && b.bready) b_pending = 1'b0;
                aw.awready = !wr_active && !b_pending && ($urandom_range(0, 3) != 0);
                if (aw.awvalid && aw.awready) begin
                    check_output("awlen", {24'd0, aw.awlen}, 32'd3);
                    wr_addr = aw.awaddr; wr_beat = 0; wr_active = 1'b1;
                    aw_count++;
                end
                w.wready = wr_active && ($urandom_range(0, 3) != 0);
                if (w.wvalid && w.wready) begin
                    check_output("wlast", {31'd0, w.wlast}, (wr_beat == 3) ? 32'd1 : 32'd0);
                    mem[widx(wr_addr)] = w.wdata;
                    wr_addr = wr_addr + 32'd4;
                    wr_beat++;
                    if (wr_beat == 4) begin
                        wr_active = 1'b0;
                        b_pending = 1'b1;
                    end
                end
            end
        end
    end

    // mode 0: identity A with ramp B, mode 1: random bytes, mode 2: large signed words
    task automatic run_matrix(input int n, input int mode, input bit busy_cmd, input string tag);
        logic [31:0] am [4][16];
        logic [31:0] bm [16][4];
        logic [31:0] expv, st;
        int ar0, aw0;
        bit done_seen;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 4; i++) begin
                case (mode)
                    0:       begin am[i][k] = (i == k) ? 32'd1 : 32'd0; bm[k][i] = 32'(4 * k + i); end
                    1:       begin am[i][k] = 32'($urandom_range(0, 255)); bm[k][i] = 32'($urandom_range(0, 255)); end
                    default: begin am[i][k] = 32'h7FFF_FFFF - 32'(7 * i + k); bm[k][i] = 32'hFFFF_FFF0 + 32'(4 * k + i); end
                endcase
                mem[widx(A_BASE + 32'((4 * k + i) * 4))] = am[i][k];
                mem[widx(B_BASE + 32'((4 * k + i) * 4))] = bm[k][i];
            end
        for (int i = 0; i < 16; i++) mem[widx(C_BASE + 32'(i * 4))] = 32'hFFFF_FFFF;
        ar0 = ar_count; aw0 = aw_count;
        apb_write(32'h100, 32'(n));
        apb_write(32'h200, A_BASE);
        apb_write(32'h204, B_BASE);
        apb_write(32'h208, C_BASE);
        apb_write(32'h20C, 32'd1);
        apb_read(32'h210, st);
        check_output({tag, "_status_clear"}, st, 32'd0);
        if (busy_cmd) begin
            repeat (6) @(negedge clk);
            apb_write(32'h20C, 32'd1);
        end
        done_seen = 1'b0;
        for (int i = 0; i < 2000 && !done_seen; i++) begin
            apb_read(32'h210, st);
            done_seen = st[0];
        end
        check_output({tag, "_done"}, {31'd0, done_seen}, 32'd1);
        check_output({tag, "_status"}, st, 32'd1);
        check_output({tag, "_ar_count"}, 32'(ar_count - ar0), 32'(2 * n));
        check_output({tag, "_aw_count"}, 32'(aw_count - aw0), 32'd4);
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 4; c++) begin
                expv = '0;
                for (int k = 0; k < n; k++) expv = expv + am[i][k] * bm[k][c];
                check_output($sformatf("%s_c%0d%0d", tag, i, c), mem[widx(C_BASE + 32'((4 * i + c) * 4))], expv);
            end
    endtask

    initial begin
        logic [31:0] rd;
        int ar0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_output("rst_arvalid", {31'd0, ar.arvalid}, 32'd0);
        check_output("rst_rready", {31'd0, r.rready}, 32'd0);
        rst_n = 1'b0;

        vecs[0]  = '{1'b0, 32'h000, 32'h0001_2021, "ip_ver"};
        vecs[1]  = '{1'b0, 32'h210, 32'h0,         "status_rst"};
        vecs[2]  = '{1'b0, 32'h100, 32'h0,         "mat_cfg_rst"};
        vecs[3]  = '{1'b1, 32'h100, 32'hDEAD_BE04, ""};
        vecs[4]  = '{1'b0, 32'h100, 32'hDEAD_BE04, "mat_cfg_full"};
        vecs[5]  = '{1'b1, 32'h100, 32'h4,         ""};
        vecs[6]  = '{1'b0, 32'h100, 32'h4,         "mat_cfg"};
        vecs[7]  = '{1'b1, 32'h200, 32'h1234_5678, ""};
        vecs[8]  = '{1'b0, 32'h200, 32'h1234_5678, "a_addr_full"};
        vecs[9]  = '{1'b1, 32'h200, 32'h0,         ""};
        vecs[10] = '{1'b0, 32'h200, 32'h0,         "a_addr"};
        vecs[11] = '{1'b1, 32'h204, 32'h1000,      ""};
        vecs[12] = '{1'b0, 32'h204, 32'h1000,      "b_addr"};
        vecs[13] = '{1'b1, 32'h208, 32'h2000,      ""};
        vecs[14] = '{1'b0, 32'h208, 32'h2000,      "c_addr"};
        vecs[15] = '{1'b0, 32'h300, 32'h0,         "unmapped"};
        for (int i = 0; i < 16; i++) apply_stimulus(vecs[i]);

        run_matrix(4, 0, 1'b0, "ident");
        for (int i = 0; i < 16; i++)
            check_output($sformatf("ident_ramp%0d", i), mem[widx(C_BASE + 32'(i * 4))], 32'(i));
        run_matrix(8, 1, 1'b0, "rand8");
        run_matrix(12, 1, 1'b0, "rand12");
        run_matrix(16, 1, 1'b0, "rand16");
        run_matrix(3, 2, 1'b0, "signed3");
        run_matrix(0, 1, 1'b0, "n0");
        run_matrix(8, 1, 1'b1, "busy");

        // Reset in the middle of the B-row read, then a clean rerun.
        apb_write(32'h100, 32'd4);
        ar0 = ar_count;
        apb_write(32'h20C, 32'd1);
        for (int i = 0; i < 300 && ar_count < ar0 + 2; i++) @(negedge clk);
        check_output("rdb_reached", 32'(ar_count - ar0), 32'd2);
        @(negedge clk);
        check_output("rdb_rready_pre", {31'd0, r.rready}, 32'd1);
        rst_n = 1'b1;
        #1;
        check_output("mid_arvalid", {31'd0, ar.arvalid}, 32'd0);
        check_output("mid_rready", {31'd0, r.rready}, 32'd0);
        check_output("mid_awvalid", {31'd0, aw.awvalid}, 32'd0);
        check_output("mid_wvalid", {31'd0, w.wvalid}, 32'd0);
        check_output("mid_bready", {31'd0, b.bready}, 32'd0);
        check_output("mid_wlast", {31'd0, w.wlast}, 32'd0);
        apb_read(32'h210, rd);
        check_output("mid_status", rd, 32'd0);
        apb_read(32'h204, rd);
        check_output("mid_b_addr", rd, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        run_matrix(4, 0, 1'b0, "rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
